// File: rtl/luffa_host_master.sv
// luffa_host_master: host-side initiator that streams 256-bit blocks into the Luffa port and fetches the digest.
module luffa_host_master #(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [255:0] blk_data,
  input  logic         blk_last,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig_data,
  output logic         err,
  output logic         init,
  output logic         load,
  output logic         fetch,
  output logic [15:0]  idata,
  input  logic         ack,
  input  logic [15:0]  odata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [3:0] {IDLE, INIT, LOAD, WAIT_ACK, NEXT, FETCH, FETCH_WAIT, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [255:0] shreg_q, shreg_d, dig_q, dig_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic last_q, last_d, err_q, err_d;
  logic init_q, init_d, load_q, load_d, fetch_q, fetch_d;
  logic [15:0] idata_q, idata_d;
  logic tmo;
  assign blk_ready = state_q == IDLE || state_q == NEXT;
  assign dig_valid = state_q == DONE;
  assign dig_data = dig_q;
  assign err = err_q;
  assign init = init_q;
  assign load = load_q;
  assign fetch = fetch_q;
  assign idata = idata_q;
  assign tmo = !ack && tcnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dig_d = dig_q;
    wcnt_d = wcnt_q;
    tcnt_d = tcnt_q;
    last_d = last_q;
    err_d = err_q;
    case (state_q)
      IDLE, NEXT: if (blk_valid) begin
        shreg_d = blk_data;
        last_d = blk_last;
        state_d = state_q == IDLE ? INIT : LOAD;
      end
      INIT: state_d = LOAD;
      LOAD: begin
        shreg_d = {shreg_q[239:0], 16'h0};
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == 4'd15) begin
          state_d = WAIT_ACK;
          tcnt_d = '0;
        end
      end
      WAIT_ACK: begin
        state_d = ack ? (last_q ? FETCH : NEXT) : tmo ? ERR : WAIT_ACK;
        err_d = err_q | tmo;
        tcnt_d = tcnt_q + CW'(1);
      end
      FETCH: begin
        state_d = FETCH_WAIT;
        tcnt_d = '0;
      end
      FETCH_WAIT: begin
        state_d = ack ? (wcnt_q == 4'd15 ? DONE : FETCH) : tmo ? ERR : FETCH_WAIT;
        err_d = err_q | tmo;
        tcnt_d = tcnt_q + CW'(1);
        if (ack) begin
          dig_d = {dig_q[239:0], odata};
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      DONE: if (dig_ready) state_d = IDLE;
      default: ;
    endcase
    if (clr) begin
      state_d = IDLE;
      err_d = 1'b0;
      wcnt_d = '0;
      tcnt_d = '0;
    end
    // Strobes follow the next state so they line up with the state they belong to.
    init_d = state_d == INIT;
    load_d = state_d == LOAD;
    fetch_d = state_d == FETCH;
    idata_d = load_d ? shreg_d[255:240] : 16'h0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dig_q <= '0;
      wcnt_q <= '0;
      tcnt_q <= '0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      init_q <= 1'b0;
      load_q <= 1'b0;
      fetch_q <= 1'b0;
      idata_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dig_q <= dig_d;
      wcnt_q <= wcnt_d;
      tcnt_q <= tcnt_d;
      last_q <= last_d;
      err_q <= err_d;
      init_q <= init_d;
      load_q <= load_d;
      fetch_q <= fetch_d;
      idata_q <= idata_d;
    end
  end
endmodule

// File: tb/tb_luffa_host_master.sv
// tb_luffa_host_master: directed/randomized bench with a bench-side core responder and message-level reference.
module tb_luffa_host_master;
  localparam int TMO = 8;
  logic clk = 0, rst_n = 0, clr = 0, blk_valid = 0, blk_last = 0, dig_ready = 0;
  logic man_ack = 0, rsp_ack = 0, fetch_seen = 0;
  logic [255:0] blk_data = '0;
  logic [15:0] odata = '0;
  logic ack, blk_ready, dig_valid, err, init, load, fetch;
  logic [255:0] dig_data;
  logic [15:0] idata;
  int total = 0, bad = 0, n_init = 0, n_fetch = 0, viol = 0;
  logic [15:0] loads[$];
  logic [15:0] digq[$];
  bit rnd_rsp = 0;
  assign ack = man_ack | rsp_ack;
  luffa_host_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_last(blk_last), .dig_valid(dig_valid), .dig_ready(dig_ready),
    .dig_data(dig_data), .err(err), .init(init), .load(load), .fetch(fetch), .idata(idata),
    .ack(ack), .odata(odata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clr_mon();
    n_init = 0;
    n_fetch = 0;
    viol = 0;
    loads.delete();
    digq.delete();
  endtask
  // One clock: sample outputs, then play the core answering each fetch one cycle later.
  task automatic step();
    @(posedge clk);
    #1;
    if (init) n_init++;
    if (load) loads.push_back(idata);
    if (blk_ready && (init || load || fetch || dig_valid || err)) viol++;
    if (fetch) n_fetch++;
    if (fetch_seen) begin
      odata = rnd_rsp ? 16'($urandom) : 16'hA000 + 16'(digq.size());
      digq.push_back(odata);
    end
    rsp_ack = fetch_seen;
    fetch_seen = fetch;
  endtask
  task automatic send(input logic [255:0] d, input bit last);
    blk_valid = 1;
    blk_data = d;
    blk_last = last;
    for (int i = 0; i < 40 && !blk_ready; i++) step();
    chk("blk_ready_accept", blk_ready, 1);
    step();
    blk_valid = 0;
  endtask
  task automatic wait_loads(input int target);
    for (int i = 0; i < 60 && !(loads.size() == target && !load); i++) step();
    chk("load_count", loads.size(), target);
  endtask
  task automatic finish_fetch();
    logic [255:0] exp;
    exp = '0;
    for (int i = 0; i < 100 && !dig_valid; i++) step();
    chk("dig_valid_rise", dig_valid, 1);
    chk("fetch_count", n_fetch, 16);
    for (int i = 0; i < 16 && i < digq.size(); i++) exp[255-16*i -: 16] = digq[i];
    chk("dig_data", dig_data, exp);
    repeat (3) step();
    chk("dig_valid_held", dig_valid, 1);
    chk("dig_data_stable", dig_data, exp);
    dig_ready = 1;
    step();
    dig_ready = 0;
    chk("dig_valid_drop", dig_valid, 0);
    chk("idle_ready", blk_ready, 1);
    chk("ready_only_idle_next", viol, 0);
  endtask
  task automatic run_msg(input int nb, input bit fixed);
    logic [255:0] blks[$];
    logic [255:0] d;
    int me;
    clr_mon();
    rnd_rsp = !fixed;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 16; j++) d[255-16*j -: 16] = fixed ? 16'(j + 1) : 16'($urandom);
      blks.push_back(d);
      send(d, b == nb - 1);
      if (b == 0) chk("init_pulse", init, 1);
      else chk("load_no_init", {init, load}, 2'b01);
      wait_loads(16 * (b + 1));
      chk("no_fetch_before_last_ack", n_fetch, 0);
      repeat (fixed ? 4 : $urandom_range(0, 5)) step();
      man_ack = 1;
      step();
      man_ack = 0;
      if (b == nb - 1) chk("fetch_after_ack", fetch, 1);
      else chk("next_ready", blk_ready, 1);
    end
    chk("init_count", n_init, 1);
    me = 0;
    for (int b = 0; b < nb; b++)
      for (int j = 0; j < 16; j++)
        if (16 * b + j >= loads.size() || loads[16*b+j] !== blks[b][255-16*j -: 16]) me++;
    chk("idata_words", me, 0);
    finish_fetch();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [255:0] r;
    #12;
    chk("rst_blk_ready", blk_ready, 1);
    chk("rst_strobes", {init, load, fetch, dig_valid, err}, 0);
    chk("rst_idata", idata, 0);
    chk("rst_dig_data", dig_data, 0);
    rst_n = 1;
    step();
    run_msg(1, 1);
    run_msg(3, 0);
    // spurious ack in IDLE and during LOAD
    clr_mon();
    rnd_rsp = 1;
    man_ack = 1;
    repeat (3) step();
    chk("spur_idle_ready", blk_ready, 1);
    chk("spur_idle_no_init", n_init, 0);
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
    send(r, 1);
    repeat (6) step();
    chk("spur_load_active", load, 1);
    man_ack = 0;
    wait_loads(16);
    chk("spur_no_fetch", fetch, 0);
    man_ack = 1;
    step();
    man_ack = 0;
    chk("spur_fetch_after_ack", fetch, 1);
    finish_fetch();
    // ack timeout
    clr_mon();
    send(r, 0);
    wait_loads(16);
    repeat (7) step();
    chk("tmo_err_not_yet", err, 0);
    step();
    chk("tmo_err_set", err, 1);
    chk("tmo_outputs_quiet", {init, load, fetch, blk_ready, dig_valid}, 0);
    man_ack = 1;
    repeat (2) step();
    man_ack = 0;
    chk("tmo_err_sticky", {err, fetch, blk_ready}, 3'b100);
    clr = 1;
    step();
    clr = 0;
    chk("tmo_clr_err", err, 0);
    chk("tmo_clr_ready", blk_ready, 1);
    // clr during LOAD
    clr_mon();
    send(r, 1);
    for (int i = 0; i < 30 && loads.size() < 7; i++) step();
    chk("clr_load_cycle7", {loads.size() == 7, load}, 2'b11);
    clr = 1;
    step();
    clr = 0;
    chk("clr_load_low", {load, idata}, 0);
    chk("clr_ready", blk_ready, 1);
    step();
    run_msg(1, 0);
    // async reset during FETCH_WAIT of word 9
    clr_mon();
    rnd_rsp = 1;
    send(r, 1);
    wait_loads(16);
    man_ack = 1;
    step();
    man_ack = 0;
    for (int i = 0; i < 80 && !(n_fetch == 9 && !fetch); i++) step();
    chk("rst_at_word9", n_fetch, 9);
    rst_n = 0;
    #1;
    chk("arst_ready", blk_ready, 1);
    chk("arst_strobes", {init, load, fetch, dig_valid, err, idata}, 0);
    chk("arst_dig_data", dig_data, 0);
    rsp_ack = 0;
    fetch_seen = 0;
    #3;
    rst_n = 1;
    step();
    run_msg(1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/luffa_host_master.md
# luffa_host_master

Host-side initiator for the Luffa 16-bit hash port.
- Accepts 256-bit message blocks from an upstream stream interface and drives init/load/fetch on the Luffa top-level port.
- Serialises each block into 16 words, waits for the core's ack, then fetches the 256-bit digest as 16 words and presents it upstream.
- Sits between the system bus/DMA side and the Luffa top-level, and is the counterpart of the port's responder.

## Interface
Parameters:
- TIMEOUT, 1023, maximum cycles spent waiting for ack before flagging an error; counter width clog2(TIMEOUT+1).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous abort; returns to IDLE from any state and clears err.
- blk_valid  in  1  upstream block valid.
- blk_ready  out  1  block accepted when blk_valid & blk_ready.
- blk_data  in  256  message block; bits [255:240] are sent first.
- blk_last  in  1  block is the final block of the message.
- dig_valid  out  1  digest valid, held until dig_ready.
- dig_ready  in  1  upstream accepts digest.
- dig_data  out  256  digest; first fetched word in [255:240].
- err  out  1  sticky ack-timeout flag.
- init  out  1  one-cycle pulse starting a new hash.
- load  out  1  idata valid strobe, one word per cycle.
- fetch  out  1  one-cycle digest-word request.
- idata  out  16  message word to core.
- ack  in  1  core response: block absorbed (after load) or odata valid (after fetch).
- odata  in  16  digest word, valid in the ack cycle.

## Operation
- States: IDLE, INIT, LOAD, WAIT_ACK, NEXT, FETCH, FETCH_WAIT, DONE, ERR.
- IDLE:
  - blk_ready=1.
  - On accept: capture blk_data into a 256-bit shift register, latch blk_last, go to INIT.
- INIT: init=1 for one cycle, then LOAD.
- LOAD:
  - load=1 and idata=shreg[255:240] for 16 consecutive cycles.
  - Shift left by 16 each cycle; 4-bit word counter.
  - Goes to WAIT_ACK after word 15.
- WAIT_ACK: on ack, go to FETCH if last is latched, otherwise go to NEXT.
- NEXT:
  - blk_ready=1.
  - On accept: capture block and last, go directly to LOAD (no init).
- FETCH: fetch=1 for one cycle, then FETCH_WAIT.
- FETCH_WAIT:
  - On ack: shift odata into the low end of the digest register (dig <= {dig[239:0], odata}) and increment the word counter.
  - After the 16th word go to DONE; otherwise return to FETCH.
- DONE:
  - dig_valid=1 and dig_data stable.
  - On dig_ready, go to IDLE. dig_data keeps its value until the next fetch.
- Timeout:
  - The wait counter is cleared on entry to WAIT_ACK or FETCH_WAIT and increments each cycle without ack.
  - When the counter reaches TIMEOUT with no ack, go to ERR and set err=1.
- ERR:
  - All strobes are 0 and blk_ready=0.
  - Only clr or reset leaves this state.
- ack in any state other than WAIT_ACK or FETCH_WAIT is ignored and does not change state.
- clr: has priority over every transition. Next state is IDLE, err=0, counters cleared, no strobe in the following cycle.

## Timing
- Reset values:
  - state=IDLE; init=load=fetch=0; idata=0.
  - blk_ready=1 (combinational from IDLE state).
  - dig_valid=0, dig_data=0, err=0.
- Strobes (init, load, fetch, idata) are registered outputs.
- First block accepted at edge T:
  - init high in cycle T+1.
  - load high in cycles T+2..T+17.
  - WAIT_ACK from T+18.
- Subsequent block accepted at edge T: load high in T+1..T+16.
- ack seen in cycle A during WAIT_ACK: fetch high in A+1 (last block) or blk_ready high in A+1.
- Each fetch/ack pair is at least 2 cycles; with ack returned the cycle after fetch, 16 words take 32 cycles.
- dig_valid rises the cycle after the 16th ack.
- blk_valid & dig_ready are sampled only in their accepting states.
- Reset asserted mid-operation: all outputs return to reset values immediately and no partial strobe continues.

## Test plan
- Single block: blk_data=256'h0001_0002_…_0010, blk_last=1; ack 5 cycles after the last load; core returns 16'hA000+i for fetch i.
  - Required: one init, idata sequence 1..16, 16 fetches, dig_data=256'hA000_A001_…_A00F, dig_valid held until dig_ready.
- Three-block message (last on block 3):
  - Exactly one init; 48 load cycles; blk_ready is high only in IDLE/NEXT; fetch starts only after the third ack.
- Timeout with TIMEOUT=8 and no ack after load:
  - err=1 exactly 8 cycles into WAIT_ACK; strobes stay 0; clr returns to IDLE with err=0.
- Spurious ack during LOAD and in IDLE:
  - No state change; the load count is still 16.
- clr asserted in cycle 7 of LOAD:
  - load=0 in the next cycle, IDLE, blk_ready=1; the following message gets a fresh init.
- rst_n asserted during FETCH_WAIT at word 9:
  - All outputs at reset values asynchronously; after release, a new single-block message completes correctly.
